rx_sample_conditioner: RTL

Clock-rate conditioning stage that sits directly upstream of the radio datapath core's RX input. It takes raw ADC sample/strobe pairs, optionally swaps I/Q, removes DC offset with a first-order IIR estimator, and decimates by a power of two with accumulate-and-dump averaging. It drives the `rx`/`rx_stb` pair consumed by RX control. It is configured over the same settings bus as the datapath core.

---
 rtl/rx_cond_pkg.sv | 31 +++
 rtl/rx_dc_offset_iir.sv | 41 ++++
 rtl/rx_sample_conditioner.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rx_cond_pkg.sv
// rtl/rx_cond_pkg.sv - shared constants, CTRL layout and saturation helper for rx_sample_conditioner
package rx_cond_pkg;

  localparam logic [7:0] REG_CTRL  = 8'd0;
  localparam logic [7:0] REG_DECIM = 8'd1;

  localparam int CTRL_SWAP_BIT  = 0;
  localparam int CTRL_DC_EN_BIT = 1;
  localparam int CTRL_K_LSB     = 4;
  localparam int CTRL_K_W       = 4;

  localparam int SAMPLE_W  = 16;
  localparam int DC_ACC_W  = 32;
  localparam int DEC_SUM_W = 24;

  localparam int MAX_LOG2_DECIM_DEF = 7;

  typedef struct packed {
    logic [CTRL_K_W-1:0] k;
    logic                dc_en;
    logic                swap_iq;
  } ctrl_t;

  // Clamp a 17-bit difference into the signed 16-bit sample range.
  function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [SAMPLE_W:0] v);
    if (v[SAMPLE_W] != v[SAMPLE_W-1])
      return v[SAMPLE_W] ? 16'h8000 : 16'h7fff;
    return v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/rx_dc_offset_iir.sv
// rtl/rx_dc_offset_iir.sv - one channel of the first-order DC-offset estimator with saturated output
module rx_dc_offset_iir
  import rx_cond_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                stb,
  input  logic                en,
  input  logic                hold_clr,
  input  logic [CTRL_K_W-1:0] k,
  input  logic [SAMPLE_W-1:0] x,
  output logic [SAMPLE_W-1:0] y,
  output logic [SAMPLE_W-1:0] est
);

  logic signed [DC_ACC_W-1:0] acc;
  logic signed [DC_ACC_W-1:0] acc_shr;
  logic        [CTRL_K_W-1:0] k_eff;
  logic        [SAMPLE_W:0]   diff;

  always_comb begin
    k_eff   = (k == '0) ? CTRL_K_W'(1) : k;
    acc_shr = acc >>> k_eff;
    est     = acc_shr[SAMPLE_W-1:0];
    diff    = {x[SAMPLE_W-1], x} - {est[SAMPLE_W-1], est};
    y       = en ? sat_sample(diff) : x;
  end

  // hold_clr follows the live dc_en so the estimate restarts from zero on re-enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (hold_clr) begin
      acc <= '0;
    end else if (stb && en) begin
      acc <= acc + {{(DC_ACC_W-SAMPLE_W){x[SAMPLE_W-1]}}, x}
                 - {{(DC_ACC_W-SAMPLE_W){est[SAMPLE_W-1]}}, est};
    end
  end

endmodule

// File: rtl/rx_sample_conditioner.sv
// rtl/rx_sample_conditioner.sv - ADC I/Q swap, DC removal (RX_COND_DC_EN) and power-of-two decimation
module rx_sample_conditioner
  import rx_cond_pkg::*;
#(
  parameter logic [7:0] SR_BASE        = 8'd160,
  parameter int         MAX_LOG2_DECIM = MAX_LOG2_DECIM_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] adc_sample,
  input  logic        adc_stb,
  output logic [31:0] out_sample,
  output logic        out_stb,
  output logic [31:0] rb_dc
);

  localparam int CNT_W = (MAX_LOG2_DECIM < 1) ? 1 : MAX_LOG2_DECIM;

  ctrl_t      ctrl_q;
  logic [2:0] decim_l;
  logic       ctrl_wr;
  logic       decim_wr;
  logic       unused_set;

  assign ctrl_wr    = set_stb && (set_addr == SR_BASE + REG_CTRL);
  assign decim_wr   = set_stb && (set_addr == SR_BASE + REG_DECIM);
  assign unused_set = ^{set_data[31:8], set_data[3:2]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      decim_l <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_q.swap_iq <= set_data[CTRL_SWAP_BIT];
        ctrl_q.dc_en   <= set_data[CTRL_DC_EN_BIT];
        ctrl_q.k       <= set_data[CTRL_K_LSB +: CTRL_K_W];
      end
      if (decim_wr)
        decim_l <= (set_data[2:0] > 3'(MAX_LOG2_DECIM)) ? 3'(MAX_LOG2_DECIM) : set_data[2:0];
    end
  end

  // Stage 1: capture, swap, and freeze the CTRL fields that apply to this sample.
  // keep marks samples that belong to the current decimation group.
  logic                s1_valid, s1_keep, s1_dc_en;
  logic [CTRL_K_W-1:0] s1_k;
  logic [SAMPLE_W-1:0] s1_i, s1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_keep  <= 1'b0;
      s1_dc_en <= 1'b0;
      s1_k     <= '0;
      s1_i     <= '0;
      s1_q     <= '0;
    end else begin
      s1_valid <= adc_stb;
      s1_keep  <= adc_stb && !decim_wr;
      if (adc_stb) begin
        s1_i     <= ctrl_q.swap_iq ? adc_sample[15:0]  : adc_sample[31:16];
        s1_q     <= ctrl_q.swap_iq ? adc_sample[31:16] : adc_sample[15:0];
        s1_dc_en <= ctrl_q.dc_en;
        s1_k     <= ctrl_q.k;
      end
    end
  end

  // Stage 2: DC removal.
  logic [SAMPLE_W-1:0] y_i, y_q, est_i, est_q;

`ifdef RX_COND_DC_EN
  rx_dc_offset_iir u_iir_i (
    .clk(clk), .reset_n(reset_n), .stb(s1_valid), .en(s1_dc_en),
    .hold_clr(!ctrl_q.dc_en), .k(s1_k), .x(s1_i), .y(y_i), .est(est_i)
  );
  rx_dc_offset_iir u_iir_q (
    .clk(clk), .reset_n(reset_n), .stb(s1_valid), .en(s1_dc_en),
    .hold_clr(!ctrl_q.dc_en), .k(s1_k), .x(s1_q), .y(y_q), .est(est_q)
  );
`else
  logic unused_dc_ctrl;
  assign unused_dc_ctrl = ^{s1_dc_en, s1_k};
  assign y_i   = s1_i;
  assign y_q   = s1_q;
  assign est_i = '0;
  assign est_q = '0;
`endif

  logic                s2_valid, s2_keep;
  logic [SAMPLE_W-1:0] s2_i, s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_keep  <= 1'b0;
      s2_i     <= '0;
      s2_q     <= '0;
      rb_dc    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_keep  <= s1_keep && !decim_wr;
      if (s1_valid) begin
        s2_i  <= y_i;
        s2_q  <= y_q;
        rb_dc <= {est_i, est_q};
      end
    end
  end

  // Stage 3: accumulate-and-dump decimation.
  logic        [CNT_W-1:0]     cnt, cnt_last;
  logic signed [DEC_SUM_W-1:0] sum_i, sum_q, sum_i_nxt, sum_q_nxt, avg_i, avg_q;

  always_comb begin
    cnt_last  = CNT_W'((1 << decim_l) - 1);
    sum_i_nxt = sum_i + {{(DEC_SUM_W-SAMPLE_W){s2_i[SAMPLE_W-1]}}, s2_i};
    sum_q_nxt = sum_q + {{(DEC_SUM_W-SAMPLE_W){s2_q[SAMPLE_W-1]}}, s2_q};
    avg_i     = sum_i_nxt >>> decim_l;
    avg_q     = sum_q_nxt >>> decim_l;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      sum_i      <= '0;
      sum_q      <= '0;
      out_sample <= '0;
      out_stb    <= 1'b0;
    end else begin
      out_stb <= 1'b0;
      if (decim_wr) begin
        cnt   <= '0;
        sum_i <= '0;
        sum_q <= '0;
      end else if (s2_valid && s2_keep) begin
        if (cnt == cnt_last) begin
          out_sample <= {avg_i[SAMPLE_W-1:0], avg_q[SAMPLE_W-1:0]};
          out_stb    <= 1'b1;
          cnt        <= '0;
          sum_i      <= '0;
          sum_q      <= '0;
        end else begin
          cnt   <= cnt + 1'b1;
          sum_i <= sum_i_nxt;
          sum_q <= sum_q_nxt;
        end
      end
    end
  end

endmodule
